ldpc_cnu: RTL
=============

LDPC_CNU -- requirements
Module: ldpc_cnu

Interface
REQ-001 SHALL have parameter QW, default 8, message width in bits (signed two's complement, >=3).
REQ-002 SHALL have parameter MAX_DEG, default 32, maximum check-node degree (>=2); DW = $clog2(MAX_DEG+1).
REQ-003 SHALL have parameter OFFSET, default 0, offset-min-sum magnitude offset (unsigned, < 2^(QW-1)).
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i  input  1  synchronous abort of current check node.
REQ-007 SHALL have port deg_i  input  DW  check-node degree, sampled on the first accepted input.
REQ-008 SHALL have port in_valid_i  input  1  input message valid.
REQ-009 SHALL have port in_ready_o  output  1  block accepts input message.
REQ-010 SHALL have port in_data_i  input  QW  variable-to-check message, signed.
REQ-011 SHALL have port out_valid_o  output  1  output message valid.
REQ-012 SHALL have port out_ready_i  input  1  consumer accepts output message.
REQ-013 SHALL have port out_data_o  output  QW  check-to-variable message, signed.
REQ-014 SHALL have port out_last_o  output  1  marks output index deg-1.
REQ-015 SHALL have port busy_o  output  1  high in COLLECT or EMIT.

Function
REQ-016 SHALL implement FSM IDLE -> COLLECT -> EMIT -> IDLE; input handshake = in_valid_i & in_ready_o, output handshake = out_valid_o & out_ready_i.
REQ-017 SHALL assert in_ready_o in IDLE and COLLECT only, out_valid_o in EMIT only; no overlap of check nodes.
REQ-018 SHALL, on IDLE input handshake, latch degree (deg_i<2 -> 2, deg_i>MAX_DEG -> MAX_DEG), process the message as index 0, and enter COLLECT (or EMIT directly never; degree >=2).
REQ-019 SHALL compute per input mag = |x| saturated to 2^(QW-1)-1 (most-negative input -> 2^(QW-1)-1) and sign = x[QW-1]; store sign per index in a MAX_DEG-bit buffer.
REQ-020 SHALL track min1, min2, idx1 and sign parity: mag < min1 -> min2=min1, min1=mag, idx1=index; else mag < min2 -> min2=mag; ties keep the earlier index as idx1.
REQ-021 SHALL enter EMIT the cycle after the handshake of index deg-1; output index counter starts at 0.
REQ-022 SHALL output for index i: m = (i==idx1 ? min2 : min1); m' = max(m-OFFSET,0); s = parity ^ sign[i]; out_data_o = s ? -m' : m'; zero magnitude always yields 0.
REQ-023 SHALL hold out_data_o and out_last_o stable while out_valid_o & !out_ready_i.
REQ-024 SHALL advance index on each output handshake; handshake at index deg-1 returns to IDLE with in_ready_o high the next cycle.
REQ-025 SHALL, on flush_i, enter IDLE next cycle from any state, discarding accumulated state; flush_i has priority over same-cycle handshakes, which are not counted.
REQ-026 SHALL produce one message per cycle throughput in both phases under continuous valid/ready; latency last input handshake to first out_valid_o = 1 cycle.

Reset
REQ-027 SHALL, while rst_ni low, force IDLE, in_ready_o=0 during reset then 1 after release, out_valid_o=0, out_last_o=0, busy_o=0, out_data_o=0, counters 0, min1/min2 = 2^(QW-1)-1, parity 0.
REQ-028 SHALL abort any COLLECT/EMIT when reset asserts mid-operation; no output is produced for the aborted node after release.

Verification
REQ-029 SHALL cover QW=8, OFFSET=0, deg=4, inputs 5,-3,7,-2 -> outputs 2,-2,2,-3, out_last_o on 4th only.
REQ-030 SHALL cover deg=2, inputs -128,10 -> outputs 10,-127 (saturation, sign parity 1).
REQ-031 SHALL cover OFFSET=1, deg=3, inputs 1,4,6 -> outputs 3,0,0; and inputs -1,4,6 -> 3,0,0 (zero never negative).
REQ-032 SHALL cover random out_ready_i backpressure on deg=MAX_DEG node -> output sequence identical to no-backpressure run, data stable while stalled.
REQ-033 SHALL cover flush_i at COLLECT index 2 and at EMIT index 1 -> IDLE next cycle, next node (deg=2, inputs 3,3 -> 3,3) correct.
REQ-034 SHALL cover rst_ni pulse mid-EMIT -> out_valid_o low asynchronously, in_ready_o high after release, next node correct.

Source files
------------

// File: rtl/ldpc_cnu.sv
// ldpc_cnu: offset-min-sum LDPC check-node unit.
// Collects deg variable-to-check messages one per cycle, then emits deg
// check-to-variable messages one per cycle. Magnitudes are tracked as the two
// smallest values plus the position of the smallest. Signs are tracked as a
// running parity plus a per-index sign buffer.
module ldpc_cnu #(
    parameter int QW      = 8,
    parameter int MAX_DEG = 32,
    parameter int OFFSET  = 0,
    localparam int DW     = $clog2(MAX_DEG + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic [DW-1:0] deg_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [QW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [QW-1:0] out_data_o,
    output logic          out_last_o,
    output logic          busy_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_EMIT    = 2'd2;

    localparam logic [QW-2:0] MAG_MAX = {(QW-1){1'b1}};
    localparam logic [QW-2:0] OFF_MAG = (QW-1)'(OFFSET);
    localparam logic [DW-1:0] DEG_MIN = DW'(2);
    localparam logic [DW-1:0] DEG_MAX = DW'(MAX_DEG);

    logic [1:0]         state_q;
    logic [DW-1:0]      deg_q;
    logic [DW-1:0]      in_idx_q;
    logic [DW-1:0]      out_idx_q;
    logic [DW-1:0]      idx1_q;
    logic [QW-2:0]      min1_q;
    logic [QW-2:0]      min2_q;
    logic               parity_q;
    logic [MAX_DEG-1:0] sign_q;

    logic               idle;
    logic               emit;
    logic               in_hs;
    logic               out_hs;
    logic               in_last;
    logic [DW-1:0]      deg_clamped;
    logic [DW-1:0]      cur_idx;
    logic [QW-1:0]      abs_full;
    logic [QW-2:0]      in_mag;
    logic [QW-2:0]      base_min1;
    logic [QW-2:0]      base_min2;
    logic [DW-1:0]      base_idx1;
    logic               base_parity;
    logic [QW-2:0]      nxt_min1;
    logic [QW-2:0]      nxt_min2;
    logic [DW-1:0]      nxt_idx1;
    logic               out_sign_bit;
    logic [QW-2:0]      sel_min;
    logic [QW-2:0]      off_mag;
    logic [QW-1:0]      pos_val;

    assign idle   = (state_q == S_IDLE);
    assign emit   = (state_q == S_EMIT);

    // Ready is held low while reset is asserted and goes high once it releases.
    assign in_ready_o  = rst_ni & ~emit;
    assign out_valid_o = emit;
    assign busy_o      = ~idle;

    assign in_hs  = in_valid_i & in_ready_o;
    assign out_hs = out_valid_o & out_ready_i;

    // The degree is clamped into [2, MAX_DEG], so a node always has a COLLECT phase.
    assign deg_clamped = (deg_i < DEG_MIN) ? DEG_MIN :
                         (deg_i > DEG_MAX) ? DEG_MAX : deg_i;

    // The first message of a node is always index 0. A new node starts from a fresh baseline.
    assign cur_idx     = idle ? '0 : in_idx_q;
    assign in_last     = (state_q == S_COLLECT) && (in_idx_q == deg_q - DW'(1));
    assign base_min1   = idle ? MAG_MAX : min1_q;
    assign base_min2   = idle ? MAG_MAX : min2_q;
    assign base_idx1   = idle ? '0 : idx1_q;
    assign base_parity = idle ? 1'b0 : parity_q;

    // Two's complement magnitude. Only the most negative code overflows, and it saturates.
    assign abs_full = in_data_i[QW-1] ? (~in_data_i + QW'(1)) : in_data_i;
    assign in_mag   = abs_full[QW-1] ? MAG_MAX : abs_full[QW-2:0];

    // Insert the incoming magnitude into the running (min1, min2, idx1) triple.
    // NOTE: every always_comb output is given a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        nxt_min1 = base_min1;
        nxt_min2 = base_min2;
        nxt_idx1 = base_idx1;
        if (in_mag < base_min1) begin
            nxt_min2 = base_min1;
            nxt_min1 = in_mag;
            nxt_idx1 = cur_idx;
        end else if (in_mag < base_min2) begin
            nxt_min2 = in_mag;
        end
    end

    // Fetch the stored sign of the message currently being answered.
    always_comb begin
        out_sign_bit = 1'b0;
        for (int k = 0; k < MAX_DEG; k++) begin
            if (out_idx_q == DW'(k)) out_sign_bit = sign_q[k];
        end
    end

    // Output for index i excludes its own input. It takes min2 at idx1 and min1 elsewhere.
    // The offset is applied afterwards, clamped at zero.
    assign sel_min = (out_idx_q == idx1_q) ? min2_q : min1_q;
    assign off_mag = (sel_min > OFF_MAG) ? (sel_min - OFF_MAG) : '0;
    assign pos_val = {1'b0, off_mag};

    // Negating a zero magnitude gives zero again, so a zero output never carries a sign.
    assign out_data_o = emit ? ((parity_q ^ out_sign_bit) ? (~pos_val + QW'(1)) : pos_val) : '0;
    assign out_last_o = emit && (out_idx_q == deg_q - DW'(1));

    // Control FSM, index counters and the running min/parity state.
    // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            deg_q     <= '0;
            in_idx_q  <= '0;
            out_idx_q <= '0;
            idx1_q    <= '0;
            min1_q    <= MAG_MAX;
            min2_q    <= MAG_MAX;
            parity_q  <= 1'b0;
        end else if (flush_i) begin
            state_q   <= S_IDLE;
            in_idx_q  <= '0;
            out_idx_q <= '0;
            idx1_q    <= '0;
            min1_q    <= MAG_MAX;
            min2_q    <= MAG_MAX;
            parity_q  <= 1'b0;
        end else begin
            if (in_hs) begin
                min1_q   <= nxt_min1;
                min2_q   <= nxt_min2;
                idx1_q   <= nxt_idx1;
                parity_q <= base_parity ^ in_data_i[QW-1];
            end
            case (state_q)
                S_IDLE: begin
                    if (in_hs) begin
                        deg_q    <= deg_clamped;
                        in_idx_q <= DW'(1);
                        state_q  <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (in_hs) begin
                        if (in_last) begin
                            in_idx_q  <= '0;
                            out_idx_q <= '0;
                            state_q   <= S_EMIT;
                        end else begin
                            in_idx_q <= in_idx_q + DW'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (out_hs) begin
                        if (out_last_o) begin
                            out_idx_q <= '0;
                            state_q   <= S_IDLE;
                        end else begin
                            out_idx_q <= out_idx_q + DW'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Per-index sign storage for the node being collected.
    // NOTE: no reset here, because each entry is written during COLLECT before EMIT reads it.
    always_ff @(posedge clk_i) begin
        if (in_hs && !flush_i) begin
            for (int k = 0; k < MAX_DEG; k++) begin
                if (cur_idx == DW'(k)) sign_q[k] <= in_data_i[QW-1];
            end
        end
    end

endmodule
